// File: rtl/tx_tlp_pkg.sv
// Shared TX TLP helpers: MWr format codes, TRN byte order, notify FSM encoding
// and the frozen per-TLP context.
package tx_tlp_pkg;

    localparam logic [6:0] FMT_MWR32 = 7'b10_00000;
    localparam logic [6:0] FMT_MWR64 = 7'b11_00000;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ARB  = 3'd1;
    localparam logic [2:0] ST_H0   = 3'd2;
    localparam logic [2:0] ST_H1   = 3'd3;
    localparam logic [2:0] ST_D    = 3'd4;

    typedef struct packed {
        logic        page2;
        logic [31:0] count;
        logic [63:0] addr;
    } notify_ctx_t;

    // Host byte 0 travels on bits [31:24] of a TRN DW lane.
    function automatic logic [31:0] trn_swap32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    // Header DW0 for a 2-DW posted write: TC, TD, EP, attr all zero.
    function automatic logic [31:0] mwr_dw0(input logic [6:0] fmt_type);
        return {1'b0, fmt_type, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, 10'd2};
    endfunction

endpackage

// File: rtl/tx_huge_page_notify_if.sv
// TRN TX link bundle; master is the TLP source, slave is the PCIe core side.
interface tx_huge_page_notify_if;
    logic [63:0] trn_td;
    logic [7:0]  trn_trem_n;
    logic        trn_tsof_n;
    logic        trn_teof_n;
    logic        trn_tsrc_rdy_n;
    logic        trn_tsrc_dsc_n;
    logic        trn_tdst_rdy_n;
    logic        trn_tdst_dsc_n;
    logic [3:0]  trn_tbuf_av;

    modport master (
        output trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n,
        input  trn_tdst_rdy_n, trn_tdst_dsc_n, trn_tbuf_av
    );

    modport slave (
        input  trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n,
        output trn_tdst_rdy_n, trn_tdst_dsc_n, trn_tbuf_av
    );
endinterface

// File: rtl/tx_notify_pending.sv
// Per-page pending latch: remembers a page_full pulse and its qword count until
// the notification for that page completes; flags a repeat while still pending.
module tx_notify_pending (
    input  logic        trn_clk,
    input  logic        trn_reset_n,
    input  logic        page_full,
    input  logic [31:0] qword_count,
    input  logic        clr,
    output logic        pend,
    output logic [31:0] count,
    output logic        ovf
);

    always_ff @(posedge trn_clk) begin
        if (!trn_reset_n) begin
            pend  <= 1'b0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (page_full) begin
            // A fresh pulse wins over a same-cycle clear so it is never lost.
            pend  <= 1'b1;
            count <= qword_count;
            if (pend && !clr)
                ovf <= 1'b1;
        end else if (clr) begin
            pend <= 1'b0;
        end
    end

endmodule

// File: rtl/tx_huge_page_notify.sv
// Sends one posted MWr status TLP per filled huge page (count + sequence) to a
// host slot, sharing the TRN TX link via the notify_turn/notify_driven handshake.
module tx_huge_page_notify
    import tx_tlp_pkg::*;
#(
    parameter int STATUS_STRIDE = 8,
    parameter int SEQ_W         = 32
) (
    input  logic        trn_clk,
    input  logic        trn_reset_n,
    input  logic [15:0] cfg_completer_id,
    input  logic [63:0] status_addr,
    input  logic        page_full_1,
    input  logic        page_full_2,
    input  logic [31:0] qword_count_1,
    input  logic [31:0] qword_count_2,
    output logic        page_notified_1,
    output logic        page_notified_2,
    output logic        notify_overflow,
    input  logic        notify_turn,
    output logic        notify_driven,
    tx_huge_page_notify_if.master trn
);

    logic [2:0]             state;
    logic                   sel;
    notify_ctx_t            ctx;
    logic [1:0][SEQ_W-1:0]  seq;
    logic [1:0]             notified;

    logic [1:0]             page_full, pend, ovf, clr;
    logic [1:0][31:0]       qword_count, pend_count;
    logic [63:0]            slot_base, sel_addr;
    logic [31:0]            seq_dw;
    logic                   is64, beat_go, abort, eof_done;

    assign page_full   = {page_full_2, page_full_1};
    assign qword_count = {qword_count_2, qword_count_1};

    for (genvar k = 0; k < 2; k++) begin : g_page
        tx_notify_pending u_pend (
            .trn_clk     (trn_clk),
            .trn_reset_n (trn_reset_n),
            .page_full   (page_full[k]),
            .qword_count (qword_count[k]),
            .clr         (clr[k]),
            .pend        (pend[k]),
            .count       (pend_count[k]),
            .ovf         (ovf[k])
        );
    end

    assign slot_base     = {status_addr[63:3], 3'b000};
    assign sel_addr      = slot_base + (sel ? 64'(STATUS_STRIDE) : 64'd0);
    assign notify_driven = (state == ST_H0) || (state == ST_H1) || (state == ST_D);
    assign abort         = notify_driven && !trn.trn_tdst_dsc_n;
    assign beat_go       = notify_driven && !trn.trn_tdst_rdy_n && trn.trn_tdst_dsc_n;
    assign eof_done      = (state == ST_D) && beat_go;
    assign clr           = {eof_done && ctx.page2, eof_done && !ctx.page2};

    assign page_notified_1 = notified[0];
    assign page_notified_2 = notified[1];
    assign notify_overflow = |ovf;

    always_ff @(posedge trn_clk) begin
        if (!trn_reset_n) begin
            state    <= ST_IDLE;
            sel      <= 1'b0;
            ctx      <= '0;
            seq      <= '0;
            notified <= '0;
        end else begin
            notified <= clr;
            case (state)
                ST_IDLE: if (|pend) begin
                    sel   <= !pend[0];
                    state <= ST_ARB;
                end
                ST_ARB: if (notify_turn && trn.trn_tbuf_av[1]) begin
                    ctx.page2 <= sel;
                    ctx.count <= pend_count[sel];
                    ctx.addr  <= sel_addr;
                    state     <= ST_H0;
                end
                ST_H0: if (abort) state <= ST_IDLE;
                       else if (beat_go) state <= ST_H1;
                ST_H1: if (abort) state <= ST_IDLE;
                       else if (beat_go) state <= ST_D;
                ST_D: if (abort) begin
                    state <= ST_IDLE;
                end else if (beat_go) begin
                    seq[ctx.page2] <= seq[ctx.page2] + SEQ_W'(1);
                    state          <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Slots above 4 GB need the 4DW header; that shifts where count and seq land.
    assign is64   = |ctx.addr[63:32];
    assign seq_dw = 32'(seq[ctx.page2]);

    always_comb begin
        trn.trn_td         = '0;
        trn.trn_trem_n     = 8'h00;
        trn.trn_tsof_n     = 1'b1;
        trn.trn_teof_n     = 1'b1;
        trn.trn_tsrc_rdy_n = !notify_driven;
        trn.trn_tsrc_dsc_n = 1'b1;
        case (state)
            ST_H0: begin
                trn.trn_td     = {mwr_dw0(is64 ? FMT_MWR64 : FMT_MWR32),
                                  cfg_completer_id, 8'h00, 4'hF, 4'hF};
                trn.trn_tsof_n = 1'b0;
            end
            ST_H1: begin
                trn.trn_td = is64 ? {ctx.addr[63:32], ctx.addr[31:2], 2'b00}
                                  : {ctx.addr[31:2], 2'b00, trn_swap32(ctx.count)};
            end
            ST_D: begin
                trn.trn_td     = is64 ? {trn_swap32(ctx.count), trn_swap32(seq_dw)}
                                      : {trn_swap32(seq_dw), 32'h0};
                trn.trn_trem_n = is64 ? 8'h00 : 8'h0F;
                trn.trn_teof_n = 1'b0;
            end
            default: ;
        endcase
    end

    logic unused_bits;
    assign unused_bits = ^{status_addr[2:0], trn.trn_tbuf_av[3:2], trn.trn_tbuf_av[0],
                           ctx.addr[1:0]};

endmodule

// File: doc/tx_huge_page_notify.md
Name: tx_huge_page_notify

Overview:
- Transmit-side counterpart of the huge-page configuration receiver.
- When the RX datapath finishes filling huge page 1 or 2, this block issues one posted Memory Write TLP on the TRN TX interface to a host status slot.
- The TLP carries the page's qword count and a sequence number. The host uses it to learn the page is full, then writes an unlock, which the receiver consumes.
- Shares the TX link with other engines through a turn/driven handshake.

Parameters:
- STATUS_STRIDE, 8, byte distance between page-1 and page-2 status slots; must be a multiple of 8.
- SEQ_W, 32, width of the per-page notification sequence counter.

Ports:
- trn_clk  in  1  TRN clock.
- trn_reset_n  in  1  synchronous active-low reset.
- cfg_completer_id  in  16  requester ID placed in header DW1.
- status_addr  in  64  host byte address of slot 0; bits [2:0] are ignored (treated as 0).
- page_full_1 / page_full_2  in  1  one-cycle pulse: the page is full.
- qword_count_1 / qword_count_2  in  32  valid with the matching page_full pulse.
- page_notified_1 / page_notified_2  out  1  one-cycle pulse when the TLP's EOF beat is accepted.
- notify_overflow  out  1  sticky flag: page_full arrived while that page was already pending.
- notify_turn  in  1  TX arbiter grants this engine the link.
- notify_driven  out  1  high from the SOF beat through the EOF beat.
- trn_td  out  64  TX data.
- trn_trem_n  out  8  remainder.
- trn_tsof_n / trn_teof_n / trn_tsrc_rdy_n / trn_tsrc_dsc_n  out  1  TRN TX controls.
- trn_tdst_rdy_n / trn_tdst_dsc_n  in  1  core flow control.
- trn_tbuf_av  in  4  buffer availability; bit 1 = posted.

Behaviour:
- Reset (synchronous, trn_reset_n==0): trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n = 1; trn_td = 0; trn_trem_n = 0; notify_driven, page_notified_*, notify_overflow = 0; pending flags = 0; sequence counters = 0; state = IDLE. Reset mid-TLP abandons the TLP without asserting EOF.
- Pending latch, per page k:
  - page_full_k sets pend_k and captures qword_count_k.
  - If pend_k is already set, notify_overflow is set and the captured count is overwritten with the new value.
  - pend_k clears in the cycle page_notified_k pulses.
- Selection in IDLE: pend_1 has priority over pend_2. A page_full arriving in the same cycle as IDLE selection is seen the next cycle (latch first, select later).
- ARB: wait until notify_turn==1 and trn_tbuf_av[1]==1. Freeze the selected page, its count, and slot address = status_addr + (k-1)*STATUS_STRIDE.
- Header:
  - fmt/type = 7'b11_00000 (MWr64, 4DW header) if slot address [63:32] != 0; otherwise 7'b10_00000 (MWr32, 3DW header).
  - Length = 2 DW, TC = 0, attr = 0.
  - DW1 = {cfg_completer_id, tag 8'h00, last BE 4'hF, first BE 4'hF}.
- Beats. Every beat is held until trn_tdst_rdy_n==0; trn_tsrc_rdy_n stays low throughout the TLP.
  - 4DW: H0 {hdrDW0, hdrDW1} sof; H1 {addr[63:32], addr[31:2], 2'b00}; D {count, seq} eof, trem_n = 8'h00.
  - 3DW: H0 {hdrDW0, hdrDW1} sof; H1 {addr[31:2], 2'b00, count}; D {seq, 32'h0} eof, trem_n = 8'h0F.
  - Payload DWs are byte-swapped into TRN order: byte 0 goes on bits [31:24] of the DW lane.
- Completion (EOF beat accepted): page_notified_k pulses, seq_k increments (wraps at 2^SEQ_W), return to IDLE. Back-to-back TLPs are allowed; at least one IDLE cycle separates them.
- Discontinue: trn_tdst_dsc_n==0 during any beat aborts the TLP. The block deasserts src_rdy and drives tsrc_dsc_n = 1 (never self-discontinues), returns to IDLE with pend_k and seq_k unchanged, and retries.
- notify_turn is sampled only in ARB. Once SOF is presented, the TLP completes regardless of notify_turn.

Decomposition:
- Shared package tx_tlp_pkg: FMT_TYPE constants (MWr32/MWr64), TRN byte-swap function, state encoding (IDLE, ARB, H0, H1, D).
- One sub-module: tx_notify_pending, the per-page pending/count/overflow latch, instantiated twice.

Test Plan:
- page_full_1, count 0x1000, status_addr 0x0000_0001_2345_6000, tdst_rdy always low -> three beats: H0 = {0x6000_0002, id,0x00,0xFF}, H1 = {0x0000_0001, 0x2345_6000}, D = {swap(0x1000), swap(0)}; page_notified_1 one cycle after EOF accepted; seq_1 = 1.
- status_addr 0x0000_0000_8000_0000, page_full_2, count 5 -> 3DW TLP to 0x8000_0008; H0 fmt 7'b10_00000; D beat trem_n = 0x0F.
- page_full_1 and page_full_2 in the same cycle -> page-1 TLP fully precedes page-2 TLP; two page_notified pulses in order.
- trn_tdst_rdy_n held high for 5 cycles on H1 -> trn_td and all control outputs stable for the whole stall.
- trn_tdst_dsc_n asserted on H1 -> abort, then retransmit with the same seq; pend stays set until the retry completes.
- page_full_1 twice with no intervening notification -> notify_overflow = 1; TLP carries the second count; one notification only.
